// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame parser.
// Frame format: SYNC, CMD, LEN, PAYLOAD[LEN], CHK (XOR of CMD, LEN, payload).
package uart_frame_pkg;

  // Parser position within a frame.
  typedef enum logic [2:0] {
    HUNT,
    CMD,
    LEN,
    PAYLOAD,
    CHK
  } state_e;

  // Default frame start marker.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Bits needed to hold a payload length of 0..max_payload.
  function automatic int len_width(input int max_payload);
    return $clog2(max_payload + 1);
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte silence counter. Counts enabled cycles since the last clear and
// raises a single-cycle expire when TIMEOUT_CYCLES is reached. A clear in the
// same cycle as the would-be expiry suppresses it (an arriving byte wins).
module uart_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry detection and next count; the counter restarts after expiring.
  always_comb begin
    expire = enable && !clear && (cnt_q == CW'(TIMEOUT_CYCLES));
    cnt_d  = cnt_q;
    if (clear || expire) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/CMD/LEN/PAYLOAD/CHK frames from a UART byte stream and
// presents validated frames on a one-entry valid/ready output slot.
// Error pulses (checksum, length, timeout, overrun) are registered.
// Optional: define UART_FRAME_STATS_EN to add saturating stat_good/stat_err
// counters.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 8,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [7:0]                          rx_data,
  input  logic                                rx_valid,
  output logic                                frm_valid,
  input  logic                                frm_ready,
  output logic [7:0]                          frm_cmd,
  output logic [len_width(MAX_PAYLOAD)-1:0]   frm_len,
  output logic [8*MAX_PAYLOAD-1:0]            frm_payload,
  output logic                                err_chk,
  output logic                                err_len,
  output logic                                err_timeout,
  output logic                                err_overrun
`ifdef UART_FRAME_STATS_EN
  ,
  output logic [15:0]                         stat_good,
  output logic [15:0]                         stat_err
`endif
);

  localparam int LW = len_width(MAX_PAYLOAD);

  // Frame assembly state.
  state_e                 state_q, state_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [LW-1:0]          len_q, len_d;
  logic [LW-1:0]          idx_q, idx_d;
  logic [7:0]             chk_q, chk_d;
  logic [8*MAX_PAYLOAD-1:0] buf_q, buf_d;

  // Output slot.
  logic                   frm_valid_q, frm_valid_d;
  logic [7:0]             frm_cmd_q, frm_cmd_d;
  logic [LW-1:0]          frm_len_q, frm_len_d;
  logic [8*MAX_PAYLOAD-1:0] frm_payload_q, frm_payload_d;

  // Registered error pulses.
  logic err_chk_q, err_chk_d;
  logic err_len_q, err_len_d;
  logic err_timeout_q, err_timeout_d;
  logic err_overrun_q, err_overrun_d;

  logic to_clear;
  logic to_enable;
  logic to_expire;
  logic frame_good;
  logic slot_free;

  // Silence is only timed while a frame is in progress.
  assign to_clear  = rx_valid || (state_q == HUNT);
  assign to_enable = (state_q != HUNT);

  uart_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (to_clear),
    .enable(to_enable),
    .expire(to_expire)
  );

  // Byte-driven frame FSM plus output slot load/handshake.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    buf_d         = buf_q;
    frm_valid_d   = frm_valid_q;
    frm_cmd_d     = frm_cmd_q;
    frm_len_d     = frm_len_q;
    frm_payload_d = frm_payload_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    frame_good    = 1'b0;
    // The slot can take a new frame if empty or being drained this cycle.
    slot_free     = !frm_valid_q || frm_ready;

    if (rx_valid) begin
      case (state_q)
        HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = CMD;
          end
        end
        CMD: begin
          cmd_d   = rx_data;
          chk_d   = rx_data;
          state_d = LEN;
        end
        LEN: begin
          if (rx_data > 8'(MAX_PAYLOAD)) begin
            err_len_d = 1'b1;
            state_d   = HUNT;
          end else begin
            len_d   = rx_data[LW-1:0];
            chk_d   = chk_q ^ rx_data;
            idx_d   = '0;
            buf_d   = '0;
            state_d = (rx_data == 8'd0) ? CHK : PAYLOAD;
          end
        end
        PAYLOAD: begin
          for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (idx_q == LW'(i)) begin
              buf_d[8*i +: 8] = rx_data;
            end
          end
          chk_d = chk_q ^ rx_data;
          idx_d = idx_q + LW'(1);
          if (idx_q == len_q - LW'(1)) begin
            state_d = CHK;
          end
        end
        CHK: begin
          if (rx_data == chk_q) begin
            frame_good = 1'b1;
          end else begin
            err_chk_d = 1'b1;
          end
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end else if (to_expire) begin
      err_timeout_d = 1'b1;
      state_d       = HUNT;
    end

    if (frm_valid_q && frm_ready) begin
      frm_valid_d = 1'b0;
    end

    if (frame_good) begin
      if (slot_free) begin
        frm_valid_d   = 1'b1;
        frm_cmd_d     = cmd_q;
        frm_len_d     = len_q;
        frm_payload_d = buf_q;
      end else begin
        err_overrun_d = 1'b1;
      end
    end
  end

  // State, slot and error registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= HUNT;
      cmd_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      buf_q         <= '0;
      frm_valid_q   <= 1'b0;
      frm_cmd_q     <= '0;
      frm_len_q     <= '0;
      frm_payload_q <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      buf_q         <= buf_d;
      frm_valid_q   <= frm_valid_d;
      frm_cmd_q     <= frm_cmd_d;
      frm_len_q     <= frm_len_d;
      frm_payload_q <= frm_payload_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign frm_valid   = frm_valid_q;
  assign frm_cmd     = frm_cmd_q;
  assign frm_len     = frm_len_q;
  assign frm_payload = frm_payload_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

`ifdef UART_FRAME_STATS_EN
  logic [15:0] stat_good_q, stat_good_d;
  logic [15:0] stat_err_q, stat_err_d;

  // Saturating counts of loaded frames and error events. A frame was loaded
  // when the slot is valid next cycle without having been held un-accepted.
  always_comb begin
    stat_good_d = stat_good_q;
    stat_err_d  = stat_err_q;
    if (frm_valid_d && !(frm_valid_q && !frm_ready) && (stat_good_q != 16'hFFFF)) begin
      stat_good_d = stat_good_q + 16'd1;
    end
    if ((err_chk_d || err_len_d || err_timeout_d || err_overrun_d) && (stat_err_q != 16'hFFFF)) begin
      stat_err_d = stat_err_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_good_q <= '0;
      stat_err_q  <= '0;
    end else begin
      stat_good_q <= stat_good_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign stat_good = stat_good_q;
  assign stat_err  = stat_err_q;
`endif

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Sits directly downstream of the UART receiver. It consumes the receiver's byte stream (data byte plus a one-cycle done tick) and assembles framed game commands of the form SYNC, CMD, LEN, PAYLOAD[LEN], CHK. Validated frames are presented to the game control logic over a valid/ready interface. It also flags checksum, length, timeout and overrun errors.

Parameters:
MAX_PAYLOAD, 8, maximum payload bytes per frame (1..15)
TIMEOUT_CYCLES, 1000000, clk cycles of inter-byte silence allowed mid-frame before abort
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
rx_data  input  8  byte from UART receiver
rx_valid  input  1  one-cycle pulse; rx_data valid this cycle
frm_valid  output  1  frame output holds a validated frame
frm_ready  input  1  consumer accepts frame
frm_cmd  output  8  command byte
frm_len  output  $clog2(MAX_PAYLOAD+1)  payload length
frm_payload  output  8*MAX_PAYLOAD  payload; byte i at [8*i +: 8]; unused bytes zero
err_chk  output  1  one-cycle pulse: checksum mismatch
err_len  output  1  one-cycle pulse: LEN > MAX_PAYLOAD
err_timeout  output  1  one-cycle pulse: inter-byte timeout mid-frame
err_overrun  output  1  one-cycle pulse: good frame dropped, output slot full

Behaviour:
- Reset (reset==0 at posedge): state HUNT; all outputs 0; working buffer, output slot and timeout counter cleared. Reset mid-frame discards the partial frame.
- Bytes are processed only on cycles where rx_valid==1.
- FSM states: HUNT, CMD, LEN, PAYLOAD, CHK.
  - HUNT: byte==SYNC_BYTE -> CMD; any other byte is ignored.
  - CMD: latch cmd; chk_acc=byte -> LEN.
  - LEN: if byte>MAX_PAYLOAD, pulse err_len and go to HUNT. Otherwise latch len, chk_acc^=byte, idx=0, clear working payload, then go to CHK if len==0, else PAYLOAD.
  - PAYLOAD: store byte at idx, chk_acc^=byte, idx++. Go to CHK after idx==len-1.
  - CHK: byte==chk_acc counts as good; otherwise pulse err_chk. Go to HUNT either way.
- A SYNC_BYTE value inside a frame is treated as ordinary data; there is no mid-frame resync.
- Checksum: 8-bit XOR of CMD, LEN and all payload bytes.
- Output slot and latency:
  - On a good CHK byte at cycle N, frm_cmd/frm_len/frm_payload load and frm_valid=1 at N+1, provided the slot is empty or being emptied (frm_valid&&frm_ready) in cycle N.
  - Otherwise the new frame is dropped, err_overrun pulses at N+1, and slot contents are unchanged.
- Handshake:
  - Transfer occurs on frm_valid&&frm_ready.
  - frm_valid then drops the next cycle unless a new frame loads that same cycle.
  - Slot outputs are stable while frm_valid==1 and not accepted.
- Timeout:
  - Counter clears on every rx_valid and while in HUNT; otherwise it increments.
  - When it reaches TIMEOUT_CYCLES, pulse err_timeout, go to HUNT, clear the counter.
  - If rx_valid and timeout expiry occur in the same cycle, the byte wins and no timeout is raised.
- Error pulses are registered (asserted the cycle after the causing byte or expiry), are mutually exclusive per frame, and last exactly one cycle.

Optional Feature:
UART_FRAME_STATS_EN:
- Defined: adds output ports stat_good[15:0] and stat_err[15:0].
  - stat_good increments on each loaded good frame.
  - stat_err increments on any err_* pulse.
  - Both are saturating at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package uart_frame_pkg:
  - state enum (HUNT, CMD, LEN, PAYLOAD, CHK)
  - default SYNC_BYTE constant
  - LEN width function
- Sub-module uart_frame_timeout: parameter TIMEOUT_CYCLES; inputs clk, reset, clear, enable; output expire pulse.

Test Plan:
- Send A5 10 02 11 22 21 with frm_ready=1 -> frm_valid for 1 cycle after last byte; cmd=10, len=2, payload[15:0]=2211, upper bytes 0; no errors.
- Send A5 10 02 11 22 20 -> err_chk pulses once, frm_valid stays 0; then A5 05 00 05 -> cmd=05, len=0, payload all zero.
- Send A5 07 09 -> err_len pulse after LEN byte; following bytes 01 02 are ignored until the next A5.
- Hold frm_ready=0; send A5 10 02 11 22 21 then A5 05 00 05 -> first frame held stable, err_overrun pulses on second; raise frm_ready -> one transfer of cmd=10.
- Send A5 10, idle TIMEOUT_CYCLES clocks -> err_timeout pulse exactly once; the next full good frame parses correctly. Also send A5 10 02 11 with reset=0 for one cycle, then release -> no output; next good frame parses.
- Back-to-back good frames with frm_ready=1 and a handshake coinciding with a CHK byte -> frm_valid stays 1 and the second frame's data loads; with UART_FRAME_STATS_EN, stat_good=2.
